// File: rtl/video_pattern_seq.sv
// Frame-synchronous test-pattern controller: six patterns selected by button or
// auto-advance, with all pattern and animation changes applied at end-of-frame.
module video_pattern_seq #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned HOLD_FRAMES = 120,
    parameter int unsigned BOX         = 64,
    parameter int unsigned STEP        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  sx,
    input  logic [9:0]  sy,
    input  logic        btn_next,
    input  logic        auto_en,
    output logic [23:0] rgb,
    output logic [2:0]  pattern,
    output logic [15:0] frame_cnt
);

    typedef enum logic {DIR_POS, DIR_NEG} dir_t;

    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] BOX_W  = 11'(BOX);
    localparam int unsigned BAR_W  = H_ACTIVE / 8;

    logic        btn_s1, btn_s2, btn_d;
    logic        btn_edge;
    logic        at_eof, prev_at_eof, eof;
    logic        pending, auto_hit, advance;
    logic [15:0] hold_cnt;
    logic [9:0]  bx, by, bx_nxt, by_nxt;
    dir_t        dir_x, dir_y, dir_x_nxt, dir_y_nxt;
    logic [2:0]  bar;
    logic        active, border, center, in_box;
    logic [23:0] rgb_nxt;

    assign btn_edge = btn_s2 & ~btn_d;
    assign at_eof   = (sx == '0) && (sy == 10'(V_ACTIVE));
    assign eof      = at_eof & ~prev_at_eof;
    assign auto_hit = auto_en && (hold_cnt == 16'(HOLD_FRAMES - 1));
    assign advance  = pending || auto_hit;

    // Reaching a bound (not only passing it) turns the box around, so it
    // rests exactly one frame on each edge.
    always_comb begin
        bx_nxt    = bx;
        dir_x_nxt = dir_x;
        if (dir_x == DIR_POS) begin
            if ({1'b0, bx} + STEP_W >= X_MAX) begin
                bx_nxt    = X_MAX[9:0];
                dir_x_nxt = DIR_NEG;
            end else begin
                bx_nxt = bx + STEP_W[9:0];
            end
        end else begin
            if ({1'b0, bx} <= STEP_W) begin
                bx_nxt    = '0;
                dir_x_nxt = DIR_POS;
            end else begin
                bx_nxt = bx - STEP_W[9:0];
            end
        end
    end

    always_comb begin
        by_nxt    = by;
        dir_y_nxt = dir_y;
        if (dir_y == DIR_POS) begin
            if ({1'b0, by} + STEP_W >= Y_MAX) begin
                by_nxt    = Y_MAX[9:0];
                dir_y_nxt = DIR_NEG;
            end else begin
                by_nxt = by + STEP_W[9:0];
            end
        end else begin
            if ({1'b0, by} <= STEP_W) begin
                by_nxt    = '0;
                dir_y_nxt = DIR_POS;
            end else begin
                by_nxt = by - STEP_W[9:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1      <= 1'b0;
            btn_s2      <= 1'b0;
            btn_d       <= 1'b0;
            prev_at_eof <= 1'b0;
            pending     <= 1'b0;
            hold_cnt    <= '0;
            pattern     <= '0;
            frame_cnt   <= '0;
            bx          <= '0;
            by          <= '0;
            dir_x       <= DIR_POS;
            dir_y       <= DIR_POS;
        end else begin
            btn_s1      <= btn_next;
            btn_s2      <= btn_s1;
            btn_d       <= btn_s2;
            prev_at_eof <= at_eof;
            if (eof) begin
                frame_cnt <= frame_cnt + 16'd1;
                bx        <= bx_nxt;
                by        <= by_nxt;
                dir_x     <= dir_x_nxt;
                dir_y     <= dir_y_nxt;
                if (advance) begin
                    pattern  <= (pattern == 3'd5) ? 3'd0 : pattern + 3'd1;
                    hold_cnt <= '0;
                    pending  <= btn_edge;
                end else begin
                    pending <= pending | btn_edge;
                    if (auto_en) hold_cnt <= hold_cnt + 16'd1;
                end
            end else begin
                pending <= pending | btn_edge;
            end
        end
    end

    always_comb begin
        bar = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (32'(sx) >= i * BAR_W) bar = bar + 3'd1;
        end
    end

    assign active = (32'(sx) < H_ACTIVE) && (32'(sy) < V_ACTIVE);
    assign border = (sx == '0) || (sx == 10'(H_ACTIVE - 1)) ||
                    (sy == '0) || (sy == 10'(V_ACTIVE - 1));
    assign center = (sx >= 10'd100) && (32'(sx) < H_ACTIVE - 100) &&
                    (sy >= 10'd100) && (32'(sy) < V_ACTIVE - 100);
    assign in_box = ({1'b0, sx} >= {1'b0, bx}) && ({1'b0, sx} < {1'b0, bx} + BOX_W) &&
                    ({1'b0, sy} >= {1'b0, by}) && ({1'b0, sy} < {1'b0, by} + BOX_W);

    always_comb begin
        rgb_nxt = '0;
        if (active) begin
            case (pattern)
                3'd0: rgb_nxt = (border || center) ? 24'hffffff : 24'h0000ff;
                3'd1: rgb_nxt = 24'hff0000;
                3'd2: begin
                    case (bar)
                        3'd0:    rgb_nxt = 24'hffffff;
                        3'd1:    rgb_nxt = 24'hffff00;
                        3'd2:    rgb_nxt = 24'h00ffff;
                        3'd3:    rgb_nxt = 24'h00ff00;
                        3'd4:    rgb_nxt = 24'hff00ff;
                        3'd5:    rgb_nxt = 24'hff0000;
                        3'd6:    rgb_nxt = 24'h0000ff;
                        default: rgb_nxt = 24'h000000;
                    endcase
                end
                3'd3: rgb_nxt = {sy[7:0], sx[7:0], 8'h00};
                3'd4: rgb_nxt = (sx[5] ^ sy[5]) ? 24'hffffff : 24'h000000;
                3'd5: rgb_nxt = in_box ? 24'hffff00 : 24'h202020;
                default: rgb_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rgb <= '0;
        else     rgb <= rgb_nxt;
    end

endmodule
